main_memory_ctrl: RTL
=====================

# main_memory_ctrl

Memory-side responder for the data cache: it serves line fills (reads) and line write-backs (writes) issued by the cache on a miss or on eviction. It holds a word-addressed 32-bit backing array with a fixed programmable access latency and moves one 4-word line per transaction in single-word beats. It sits below `cache` and replaces the flat zero-latency memory model with a handshaked, multi-cycle one.

## Interface

- `LATENCY`, 4: wait cycles between request acceptance and the first beat; legal range 1..15.
- `DEPTH`, 256: number of 32-bit words in the backing array; a power of 2 with `DEPTH*4 <= 1024`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  in  1  request valid; held high until `mem_ack`.
- `mem_write`  in  1  1 = write-back, 0 = line fill; sampled with `mem_req`.
- `mem_addr`  in  10  byte address; bits [3:0] select the word and byte within the line.
- `mem_wdata`  in  32  write beat data; sampled on each cycle that `mem_wready` is high.
- `mem_wready`  out  1  write beat consumed this cycle.
- `mem_rdata`  out  32  read beat data; valid while `mem_rvalid` is high.
- `mem_rvalid`  out  1  read beat valid.
- `mem_ack`  out  1  one-cycle pulse marking transaction end.
- `mem_busy`  out  1  high in every state except IDLE.

## Operation

- Backing array is named `memory[0:DEPTH-1]`, 32 bits wide, and indexed by `mem_addr[9:2]` modulo DEPTH. The bench reads it hierarchically.
- The array is not cleared by `rst`; its contents persist.
- FSM states are IDLE, WAIT, BURST and DONE.
- **IDLE**
  - When `mem_req=1`, latch the line base `mem_addr[9:4]`, the start word and `mem_write`.
  - Load the wait counter with `LATENCY-1` and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle. At 0, clear the beat counter and go to BURST.
- **BURST**
  - Runs exactly 4 beats, one per cycle, with the beat counter counting 0..3.
  - The word index is `{base, (start + beat) mod 4}`; the 2-bit add wraps.
  - Read: drive `mem_rvalid=1` and `mem_rdata=memory[index]`.
  - Write: drive `mem_wready=1`; `memory[index] <= mem_wdata` at that cycle's edge.
  - After beat 3, go to DONE.
- **DONE**
  - Drive `mem_ack=1` for one cycle, then return to IDLE.
- Inputs are ignored outside IDLE. Changes to `mem_addr` or `mem_write` mid-transaction have no effect.
- The requester drops `mem_req` in the cycle after `mem_ack`. If `mem_req` is still high in IDLE, it is a new request.
- Read beats reflect array contents at beat time. No read-after-write hazard exists, because transactions never overlap.

## Timing

- Reset values: FSM is IDLE; `mem_rvalid`, `mem_wready`, `mem_ack` and `mem_busy` are 0; `mem_rdata` is 32'h0.
- Reset mid-transaction aborts immediately (next cycle is IDLE with outputs as above). Beats already written stay written, so a partially written line is possible.
- Take accept edge E0 (IDLE with `mem_req=1`).
  - `mem_busy` is high from E0 until the edge after the `mem_ack` cycle.
  - Beats occupy the cycles following edges E0+LATENCY through E0+LATENCY+3.
  - `mem_ack` is high in the cycle following edge E0+LATENCY+4.
- Total occupancy is LATENCY+5 cycles.
- Minimum spacing between two accepts is LATENCY+6 edges.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- `MEM_CRITICAL_WORD_FIRST_EN` defined:
  - The start word is `mem_addr[3:2]`.
  - Reads return the requested word first, then wrap within the line (e.g. start 2 gives order 2,3,0,1).
  - Writes use the same ordering.
- Undefined:
  - The start word is forced to 0 and beats are always in order 0,1,2,3.
  - `mem_addr[3:0]` is ignored.

## Test plan

- Reset mid-burst: assert `rst` during beat 2 of a write to line 2 -> next cycle IDLE, all outputs 0; `memory[8]` and `memory[9]` updated, `memory[10]` and `memory[11]` unchanged.
- Fill, LATENCY=4, macro off: preload `memory[0..3]=32'h11,22,33,44`, request read at 10'h000 accepted at E0 -> `mem_rvalid` after edges E0+4..E0+7 with rdata 11,22,33,44; `mem_ack` after E0+8; `mem_busy` high through the ack cycle.
- Write-back: write at 10'h200 with beats FF,EE,DD,CC -> `mem_wready` 4 cycles; `memory[128..131]=FF,EE,DD,CC`; a subsequent fill of 10'h200 returns FF,EE,DD,CC.
- Critical word first, macro on: read at 10'h008 with `memory[0..3]=A0,A1,A2,A3` -> order A2,A3,A0,A1. Macro off -> order A0,A1,A2,A3.
- Back-to-back: `mem_req` held high through `mem_ack` -> second transaction accepted in the following IDLE cycle. Inputs changed during WAIT -> first transaction completes unaffected.

Source files
------------

// File: rtl/main_memory_ctrl.sv
// Handshaked line-fill / write-back responder with fixed access latency and 4-beat bursts.
// Optional MEM_CRITICAL_WORD_FIRST_EN: bursts start at the requested word and wrap within the line.
module main_memory_ctrl #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [9:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_wready,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        mem_ack,
    output logic        mem_busy,
    output logic [1:0]  dbg_state
);
    // Handshake: mem_req/mem_write/mem_addr are sampled only in IDLE; the requester holds
    // mem_req until mem_ack and drops it the cycle after. mem_wready marks the cycle whose
    // mem_wdata is consumed, mem_rvalid the cycle whose mem_rdata is valid.
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t      state;
    logic [31:0] memory [0:DEPTH-1];
    logic [5:0]  base_q;
    logic [1:0]  start_q;
    logic [1:0]  beat_q;
    logic        write_q;
    logic [3:0]  wait_cnt;
    logic [1:0]  req_start;
    logic [1:0]  next_beat;
    logic [7:0]  rd_word;
    logic [7:0]  wr_word;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign req_start = mem_addr[3:2];
`else
    assign req_start = 2'd0;
`endif

    // Read data is registered one cycle ahead, so reads look up the beat about to be presented.
    always_comb begin
        next_beat = (state == BURST) ? 2'(beat_q + 2'd1) : 2'd0;
        rd_word   = {base_q, 2'(start_q + next_beat)};
        wr_word   = {base_q, 2'(start_q + beat_q)};
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= '0;
            start_q    <= '0;
            beat_q     <= '0;
            write_q    <= 1'b0;
            wait_cnt   <= '0;
            mem_wready <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_ack    <= 1'b0;
            mem_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        base_q   <= mem_addr[9:4];
                        start_q  <= req_start;
                        write_q  <= mem_write;
                        wait_cnt <= 4'(LATENCY - 1);
                        mem_busy <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        beat_q     <= 2'd0;
                        mem_rvalid <= !write_q;
                        mem_wready <= write_q;
                        if (!write_q)
                            mem_rdata <= memory[rd_word[AW-1:0]];
                        state      <= BURST;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (beat_q == 2'd3) begin
                        mem_rvalid <= 1'b0;
                        mem_wready <= 1'b0;
                        mem_rdata  <= '0;
                        mem_ack    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                        if (!write_q)
                            mem_rdata <= memory[rd_word[AW-1:0]];
                    end
                end
                DONE: begin
                    mem_ack  <= 1'b0;
                    mem_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset; a reset during a write beat suppresses that beat's store.
    always_ff @(posedge clk) begin
        if (!rst && state == BURST && write_q)
            memory[wr_word[AW-1:0]] <= mem_wdata;
    end

endmodule
